io_output_queue: RTL and testbench
==================================

IO_OUTPUT_QUEUE -- requirements
Module: io_output_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 36, giving the data word width; it equals the CPU datapath width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clock, input, 1 bit: the single rising-edge clock shared with the CPU.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset.
REQ-006 Port outFlag, input, 1 bit: push strobe from the CPU execute stage (CPU outFlagIOE).
REQ-007 Port dataIn, input, WIDTH bits: word to enqueue (CPU out).
REQ-008 Port readyOut, input, 1 bit: the downstream sink accepts dataOut this cycle.
REQ-009 Port validOut, output, 1 bit: dataOut holds a valid head entry.
REQ-010 Port dataOut, output, WIDTH bits: the oldest queued word.
REQ-011 Port count, output, log2(DEPTH)+1 bits: the current number of occupied entries.
REQ-012 Port full, output, 1 bit: high when count == DEPTH.
REQ-013 Port empty, output, 1 bit: high when count == 0.
REQ-014 Port stallRequest, output, 1 bit: high when count >= DEPTH-1; it is intended to drive the CPU stallF/stallD/flushE path.
REQ-015 Port overflow, output, 1 bit: sticky flag set when a push is dropped.

Function
REQ-016 Storage SHALL be a circular buffer with write pointer wp, read pointer rp and a registered count.
REQ-017 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 A pop SHALL occur on a rising edge when validOut && readyOut.
REQ-019 A push SHALL occur on a rising edge when outFlag && (!full || pop).
REQ-020 On a push, dataIn SHALL be written at wp and wp SHALL advance by 1.
REQ-021 On a pop, rp SHALL advance by 1.
REQ-022 Count update: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged; neither leaves count unchanged.
REQ-023 The queue SHALL be first-word-fall-through: validOut = !empty, and dataOut = mem[rp] when !empty, else all zeros.
REQ-024 Latency: a word pushed on edge N SHALL appear on dataOut with validOut=1 in the cycle after edge N when the queue was empty. Combinational bypass from dataIn to dataOut is prohibited.
REQ-025 Full, no pop: a push SHALL be dropped, storage and pointers SHALL be unchanged, and overflow SHALL set to 1.
REQ-026 Full with a simultaneous pop: the push SHALL be accepted and count SHALL stay DEPTH.
REQ-027 Empty: readyOut SHALL have no effect; pointers and count SHALL be unchanged and no underflow is possible.
REQ-028 overflow SHALL remain 1 until reset.
REQ-029 full, empty and stallRequest SHALL be combinational decodes of the registered count only; outFlag and readyOut SHALL not feed them.
REQ-030 Words SHALL leave the queue in exact push order, with no duplication or loss except the drops under REQ-025.

Reset
REQ-031 While reset=1 on a rising edge, wp, rp, count and overflow SHALL clear to 0; the outputs are then validOut=0, dataOut=0, empty=1, full=0, stallRequest=0, count=0.
REQ-032 Reset SHALL take priority over a simultaneous push or pop.
REQ-033 A reset mid-operation SHALL discard all queued words; the memory array itself needs no reset.
REQ-034 The first push after reset is deasserted SHALL land at entry 0.

Verification (DEPTH=8, WIDTH=36)
REQ-035 Reset, then one push of 36'h0_0000_00A5 with readyOut=0 -> on the next cycle validOut=1, dataOut=36'hA5, count=1, empty=0.
REQ-036 Eight pushes of 1..8 with readyOut=0:
- after the 7th push, count=7 and stallRequest=1;
- after the 8th push, full=1;
- a 9th push of 9 leaves count=8, sets overflow=1, and the head stays 1.
REQ-037 Full queue, then outFlag=1 with dataIn=9 and readyOut=1 in the same cycle -> count stays 8; draining yields 2,3,4,5,6,7,8,9.
REQ-038 Push 12 words while readyOut=1 throughout, one push per cycle -> pointers wrap, count never exceeds 1, output order is 1..12, overflow=0.
REQ-039 Empty queue, readyOut=1 for 3 cycles -> count=0, validOut=0, dataOut=0, and pointers unchanged.
REQ-040 Queue holding 5 words with overflow=1, then reset=1 for one cycle together with outFlag=1 -> count=0, overflow=0, validOut=0; the next push appears alone at the head.

Source files
------------

// File: rtl/io_output_queue.sv
// First-word-fall-through output queue between the CPU execute stage and a downstream sink.
// Circular buffer with registered pointers and count; drops pushes when full unless a pop frees a slot.
module io_output_queue #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     outFlag,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     readyOut,
    output logic                     validOut,
    output logic [WIDTH-1:0]         dataOut,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     stallRequest,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic pop_c;
    logic push_c;

    // Status decodes depend on the registered count only, never on the strobes.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign stallRequest = (count_q >= CW'(DEPTH - 1));
    assign count        = count_q;
    assign overflow     = overflow_q;

    assign validOut = !empty;
    assign dataOut  = empty ? '0 : mem_q[rp_q];

    // A pop frees the head slot on the same edge, so a full queue can still accept a push.
    assign pop_c  = validOut && readyOut;
    assign push_c = outFlag && (!full || pop_c);

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_c) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop_c) begin
            rp_d = rp_q + AW'(1);
        end

        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end

        if (outFlag && !push_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push_c && !reset) begin
            mem_q[wp_q] <= dataIn;
        end
    end

endmodule

// File: tb/tb_io_output_queue.sv
// Bench for io_output_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_io_output_queue;

    localparam int unsigned WIDTH = 36;
    localparam int unsigned DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             outFlag;
    logic [WIDTH-1:0] dataIn;
    logic             readyOut;
    logic             validOut;
    logic [WIDTH-1:0] dataOut;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             stallRequest;
    logic             overflow;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] mq[$];
    logic             m_ovf;
    logic [WIDTH-1:0] dut_log[$];

    io_output_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .outFlag(outFlag), .dataIn(dataIn),
        .readyOut(readyOut), .validOut(validOut), .dataOut(dataOut), .count(count),
        .full(full), .empty(empty), .stallRequest(stallRequest), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus a sticky drop flag.
    always @(posedge clock) begin
        bit m_pop, m_push;
        if (validOut && readyOut && !reset) dut_log.push_back(dataOut);
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = (mq.size() > 0) && readyOut;
            m_push = outFlag && ((mq.size() < DEPTH) || m_pop);
            if (outFlag && !m_push) m_ovf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(dataIn);
        end
    end

    // Outputs depend only on registered state, so mid-cycle sampling is stable.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("count",    64'(count),        64'(mq.size()));
            chk("validOut", 64'(validOut),     64'(mq.size() > 0));
            chk("dataOut",  64'(dataOut),      (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
            chk("full",     64'(full),         64'(mq.size() == DEPTH));
            chk("empty",    64'(empty),        64'(mq.size() == 0));
            chk("stall",    64'(stallRequest), 64'(mq.size() >= DEPTH - 1));
            chk("overflow", 64'(overflow),     64'(m_ovf));
        end
    end

    task automatic cyc(input logic rst, input logic of, input logic [WIDTH-1:0] din, input logic rdy);
        @(negedge clock);
        reset    = rst;
        outFlag  = of;
        dataIn   = din;
        readyOut = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic chk_log(input string name, input int first, input int n);
        chk({name, "_len"}, 64'(dut_log.size()), 64'(n));
        for (int i = 0; i < n && i < dut_log.size(); i++)
            chk(name, 64'(dut_log[i]), 64'(first + i));
    endtask

    initial begin
        int max_cnt;
        reset = 1'b1; outFlag = 1'b0; dataIn = '0; readyOut = 1'b0;
        do_reset();
        chk_en = 1'b1;

        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_valid", 64'(validOut), 64'd0);
        chk("rst_data",  64'(dataOut), 64'd0);

        // Single push appears at the head one cycle later.
        cyc(1'b0, 1'b1, 36'h0_0000_00A5, 1'b0);
        chk("p1_valid", 64'(validOut), 64'd1);
        chk("p1_data",  64'(dataOut), 64'hA5);
        chk("p1_count", 64'(count), 64'd1);
        chk("p1_empty", 64'(empty), 64'd0);

        // Fill to the brim, then overflow.
        do_reset();
        for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b1, WIDTH'(i), 1'b0);
        chk("f7_count", 64'(count), 64'd7);
        chk("f7_stall", 64'(stallRequest), 64'd1);
        chk("f7_full",  64'(full), 64'd0);
        cyc(1'b0, 1'b1, WIDTH'(8), 1'b0);
        chk("f8_full",  64'(full), 64'd1);
        cyc(1'b0, 1'b1, WIDTH'(9), 1'b0);
        chk("f9_count", 64'(count), 64'd8);
        chk("f9_ovf",   64'(overflow), 64'd1);
        chk("f9_head",  64'(dataOut), 64'd1);
        chk("model_ovf", 64'(m_ovf), 64'd1);

        // Full queue with simultaneous push and pop.
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, WIDTH'(i), 1'b0);
        cyc(1'b0, 1'b1, WIDTH'(9), 1'b1);
        chk("fp_count", 64'(count), 64'd8);
        chk("fp_ovf",   64'(overflow), 64'd0);
        dut_log.delete();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0, 1'b1);
        chk_log("drain", 2, 8);
        chk("drain_empty", 64'(empty), 64'd1);

        // Streaming with the sink always ready: pointers wrap, depth stays at one.
        do_reset();
        dut_log.delete();
        max_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 1'b1, WIDTH'(i), 1'b1);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("stream_max", 64'(max_cnt), 64'd1);
        chk_log("stream", 1, 12);
        chk("stream_ovf", 64'(overflow), 64'd0);

        // Pops on an empty queue are ignored.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1);
        chk("e_count", 64'(count), 64'd0);
        chk("e_valid", 64'(validOut), 64'd0);
        chk("e_data",  64'(dataOut), 64'd0);
        cyc(1'b0, 1'b1, WIDTH'(36'h55), 1'b0);
        chk("e_head",  64'(dataOut), 64'h55);
        chk("e_cnt1",  64'(count), 64'd1);

        // Reset mid-operation wins over a push and discards contents.
        do_reset();
        for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b1, WIDTH'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1);
        chk("r5_count", 64'(count), 64'd5);
        chk("r5_ovf",   64'(overflow), 64'd1);
        cyc(1'b1, 1'b1, WIDTH'(36'h99), 1'b0);
        chk("r_count", 64'(count), 64'd0);
        chk("r_ovf",   64'(overflow), 64'd0);
        chk("r_valid", 64'(validOut), 64'd0);
        cyc(1'b0, 1'b1, WIDTH'(36'h77), 1'b0);
        chk("r_head",  64'(dataOut), 64'h77);
        chk("r_cnt1",  64'(count), 64'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("r_alone", 64'(empty), 64'd1);

        // Randomized traffic with varying push/pop pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int pp, rp;
            pp = (i / 500) % 3 == 0 ? 80 : ((i / 500) % 3 == 1 ? 40 : 60);
            rp = (i / 500) % 3 == 0 ? 30 : ((i / 500) % 3 == 1 ? 80 : 60);
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 99) < pp),
                {4'($urandom), 32'($urandom)},
                ($urandom_range(0, 99) < rp));
        end
        cyc(1'b0, 1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
